// File: rtl/audipus_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner encoding and default widths.
package audipus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_AUD = 1'b0,
      OWN_CPU = 1'b1
   } owner_e;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 8;
   localparam int TMO_W      = 8;

endpackage

// File: rtl/sram_arb_prio.sv
// Winner select between audio and CPU, with a saturating counter that bounds
// how many audio grants a pending CPU request can be made to wait behind.
module sram_arb_prio
   import audipus_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   aud_req,
   input  logic   cpu_req,
   input  logic   idle,
   input  logic   grant,
   output owner_e winner
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   assign starved = (starve_cnt == CW'(STARVE_MAX));

   always_comb begin
      winner = OWN_AUD;
      if (cpu_req && (!aud_req || starved))
         winner = OWN_CPU;
   end

   // Any grant reaching the increment branch is an audio grant with cpu_req high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if ((idle && !cpu_req) || (grant && winner == OWN_CPU))
         starve_cnt <= '0;
      else if (grant && !starved)
         starve_cnt <= starve_cnt + 1'b1;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (audio, CPU) arbiter in front of a single-transfer SRAM interface,
// with capture of the winning request, a per-transfer timeout and a sticky error flag.
module sram_arbiter
   import audipus_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              aud_req,
   input  logic              aud_we,
   input  logic [ADDR_W-1:0] aud_addr,
   input  logic [DATA_W-1:0] aud_wdata,
   output logic              aud_gnt,
   output logic              aud_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_busy,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout_err,
   input  logic              err_clr,
   output logic              owner
);

   // Counter value on the last WAIT cycle before the transfer is abandoned.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   arb_state_e       state_q, state_d;
   owner_e           winner, owner_q;
   logic [TMO_W-1:0] tmo_cnt;
   logic             go, in_wait, tmo_hit, finish;

   assign go      = (state_q == ST_IDLE) && (aud_req || cpu_req) && !mem_busy;
   assign in_wait = (state_q == ST_WAIT);
   assign tmo_hit = in_wait && !mem_done && (tmo_cnt == TMO_LAST);
   assign finish  = in_wait && (mem_done || tmo_hit);
   assign owner   = owner_q;

   sram_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk     (clk),
      .reset_n (reset_n),
      .aud_req (aud_req),
      .cpu_req (cpu_req),
      .idle    (state_q == ST_IDLE),
      .grant   (go),
      .winner  (winner)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_start = 1'b0;
      aud_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      case (state_q)
         ST_IDLE:  if (go) state_d = ST_ISSUE;
         ST_ISSUE: begin
            mem_start = 1'b1;
            aud_gnt   = (owner_q == OWN_AUD);
            cpu_gnt   = (owner_q == OWN_CPU);
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_done)     state_d = ST_DONE;
            else if (tmo_hit) state_d = ST_IDLE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A timeout still produces a done pulse (with zero data) so the requester never hangs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q     <= OWN_AUD;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
         rdata       <= '0;
         aud_done    <= 1'b0;
         cpu_done    <= 1'b0;
      end else begin
         aud_done <= finish && (owner_q == OWN_AUD);
         cpu_done <= finish && (owner_q == OWN_CPU);

         if (go) begin
            owner_q <= winner;
            if (winner == OWN_CPU) begin
               mem_we    <= cpu_we;
               mem_addr  <= cpu_addr;
               mem_wdata <= cpu_wdata;
            end else begin
               mem_we    <= aud_we;
               mem_addr  <= aud_addr;
               mem_wdata <= aud_wdata;
            end
         end

         if (state_q == ST_ISSUE)
            tmo_cnt <= '0;
         else if (in_wait)
            tmo_cnt <= tmo_cnt + 1'b1;

         if (in_wait && mem_done)
            rdata <= mem_rdata;
         else if (tmo_hit)
            rdata <= '0;

         if (tmo_hit)
            timeout_err <= 1'b1;
         else if (err_clr)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table of single transfers, directed corner
// sequences, and a randomized run against a transaction-level model.
module tb_sram_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 8;
   localparam int SMAX   = 4;
   localparam int TMO    = 255;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              aud_req, aud_we, cpu_req, cpu_we;
   logic [ADDR_W-1:0] aud_addr, cpu_addr, mem_addr;
   logic [DATA_W-1:0] aud_wdata, cpu_wdata, mem_wdata, rdata, mem_rdata;
   logic              aud_gnt, aud_done, cpu_gnt, cpu_done;
   logic              mem_start, mem_we, mem_busy, mem_done;
   logic              timeout_err, err_clr, owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .aud_req(aud_req), .aud_we(aud_we), .aud_addr(aud_addr), .aud_wdata(aud_wdata),
      .aud_gnt(aud_gnt), .aud_done(aud_done),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
      .rdata(rdata), .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err), .err_clr(err_clr), .owner(owner)
   );

   typedef struct {
      logic        cpu;
      logic        we;
      logic [23:0] addr;
      logic [7:0]  wdata;
      int          lat;
      logic [7:0]  mrd;
      logic        exp_owner;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs [5];

   // model / scoreboard state
   int          m_starve, due, grants, ng, k;
   logic        m_owner, outst, exp_w, prev_a, prev_c, prev_busy, held, quiet;
   logic [23:0] cap_addr;
   logic [7:0]  cap_wdata, exp_rd;
   logic        cap_we;
   logic        seq [10];
   logic        exp_seq [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      aud_req = 0; aud_we = 0; aud_addr = '0; aud_wdata = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      mem_busy = 0; mem_done = 0; mem_rdata = '0; err_clr = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;
   endtask

   task automatic wait_start(input string nm);
      int n = 0;
      while (!mem_start && n < 20) begin
         step();
         n++;
      end
      chk(nm, 32'(mem_start), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      aud_req = !v.cpu; cpu_req = v.cpu;
      if (v.cpu) begin
         cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
         aud_we = ~v.we; aud_addr = ~v.addr; aud_wdata = ~v.wdata;
      end else begin
         aud_we = v.we; aud_addr = v.addr; aud_wdata = v.wdata;
         cpu_we = ~v.we; cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
      end
      wait_start("vec_start");
      chk("vec_gnt", 32'({aud_gnt, cpu_gnt}), 32'(v.exp_owner ? 2'b01 : 2'b10));
      chk("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
      chk("vec_mem_we_wdata", 32'({mem_we, mem_wdata}), 32'({v.we, v.wdata}));
      chk("vec_owner", 32'(owner), 32'(v.exp_owner));
      // request withdrawn and its fields scrambled; the transfer must not notice
      aud_req = 0; cpu_req = 0;
      aud_addr = 24'h13579B; cpu_addr = 24'h2468AC; aud_wdata = 8'h11; cpu_wdata = 8'h22;
      aud_we = ~v.we; cpu_we = ~v.we;
      held = 1;
      repeat (v.lat) begin
         step();
         if (mem_addr !== v.addr || mem_wdata !== v.wdata || mem_we !== v.we ||
             mem_start || aud_done || cpu_done || aud_gnt || cpu_gnt)
            held = 0;
      end
      chk("vec_held", 32'(held), 32'd1);
      mem_done = 1; mem_rdata = v.mrd;
      step();
      mem_done = 0; mem_rdata = 8'hEE;
      chk("vec_done", 32'({aud_done, cpu_done}), 32'(v.exp_owner ? 2'b01 : 2'b10));
      chk("vec_rdata", 32'(rdata), 32'(v.exp_rdata));
      step();
      chk("vec_done_pulse", 32'({aud_done, cpu_done}), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal;
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 24'h000123, 8'hA5, 5, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 24'h0ABCDE, 8'h00, 2, 8'h3C, 1'b1, 8'h3C};
      vecs[2] = '{1'b0, 1'b0, 24'hFFFFFF, 8'h00, 1, 8'hFF, 1'b0, 8'hFF};
      vecs[3] = '{1'b1, 1'b1, 24'h000000, 8'h5A, 3, 8'h81, 1'b1, 8'h81};
      vecs[4] = '{1'b0, 1'b0, 24'h800001, 8'h00, 7, 8'h6E, 1'b0, 8'h6E};
      exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // reset state, with a request present that must not be granted
      clr_inputs();
      #1 reset_n = 0;
      aud_req = 1; aud_addr = 24'hABCDEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pulses", 32'({aud_gnt, aud_done, cpu_gnt, cpu_done, mem_start}), 32'd0);
      chk("rst_regs", 32'({mem_we, owner, timeout_err, rdata, mem_wdata}), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      aud_req = 0;
      reset_n = 1;
      step();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // mem_busy stall
      mem_busy = 1; aud_req = 1; aud_we = 0; aud_addr = 24'h0000B5;
      quiet = 1;
      repeat (5) begin
         step();
         if (mem_start || aud_gnt || cpu_gnt) quiet = 0;
      end
      chk("busy_stall", 32'(quiet), 32'd1);
      mem_busy = 0;
      step();
      chk("busy_release", 32'({mem_start, aud_gnt}), 32'(2'b11));
      aud_req = 0;
      step();
      mem_done = 1; mem_rdata = 8'h42;
      step();
      mem_done = 0;
      chk("busy_done", 32'({aud_done, rdata}), 32'({1'b1, 8'h42}));
      step();

      // timeout with nonzero rdata left from the previous transfer
      aud_req = 1; aud_we = 0; aud_addr = 24'h00BEEF;
      wait_start("tmo_start");
      aud_req = 0;
      k = 0;
      while (!timeout_err && k < 300) begin
         step();
         k++;
      end
      chk("tmo_latency", 32'(k), 32'd256);
      chk("tmo_done", 32'({aud_done, cpu_done}), 32'(2'b10));
      chk("tmo_rdata", 32'(rdata), 32'd0);
      step();
      chk("tmo_sticky", 32'({timeout_err, aud_done}), 32'(2'b10));
      err_clr = 1;
      step();
      err_clr = 0;
      chk("tmo_err_clr", 32'(timeout_err), 32'd0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000777;
      step();
      chk("tmo_back_idle", 32'({mem_start, cpu_gnt}), 32'(2'b11));
      cpu_req = 0;
      step();
      mem_done = 1; mem_rdata = 8'h99;
      step();
      mem_done = 0;
      chk("tmo_next_rdata", 32'({cpu_done, rdata}), 32'({1'b1, 8'h99}));
      step();

      // timeout while err_clr is held: the set must win
      err_clr = 1; aud_req = 1;
      wait_start("tmo2_start");
      aud_req = 0;
      k = 0;
      while (!timeout_err && k < 300) begin
         step();
         k++;
      end
      chk("tmo_set_wins", 32'(k), 32'd256);
      step();
      chk("tmo2_clr", 32'(timeout_err), 32'd0);
      err_clr = 0;

      // reset during WAIT, then a stray mem_done
      cpu_req = 1; cpu_we = 1; cpu_addr = 24'h5A5A5A; cpu_wdata = 8'hC3;
      wait_start("rstw_start");
      cpu_req = 0;
      step(); step();
      reset_n = 0;
      #1;
      chk("rstw_pulses", 32'({aud_gnt, aud_done, cpu_gnt, cpu_done, mem_start}), 32'd0);
      chk("rstw_regs", 32'({mem_we, owner, timeout_err, rdata, mem_wdata}), 32'd0);
      chk("rstw_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1;
      mem_done = 1; mem_rdata = 8'h77;
      quiet = 1;
      repeat (4) begin
         step();
         mem_done = 0;
         if (aud_done || cpu_done || mem_start || aud_gnt || cpu_gnt) quiet = 0;
      end
      chk("rstw_stray_ignored", 32'(quiet), 32'd1);
      chk("rstw_rdata", 32'(rdata), 32'd0);
      aud_req = 1;
      step();
      chk("rstw_idle", 32'({mem_start, aud_gnt}), 32'(2'b11));

      // starvation bound with both requesters always asserted
      do_reset();
      aud_req = 1; cpu_req = 1; aud_addr = 24'h000A00; cpu_addr = 24'h000C00;
      ng = 0; due = -1;
      for (int n = 0; n < 300 && ng < 10; n++) begin
         if (mem_start) begin
            seq[ng] = cpu_gnt;
            ng++;
            due = n + 1;
         end
         mem_done = (n == due);
         step();
      end
      chk("starve_grants", 32'(ng), 32'd10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

      // randomized traffic against a transaction-level model
      do_reset();
      m_starve = 0; m_owner = 0; outst = 0; grants = 0; due = 0;
      prev_a = 0; prev_c = 0; prev_busy = 0;
      for (int n = 0; n < 4000; n++) begin
         if (outst) begin
            chk("rnd_hold_addr", 32'(mem_addr), 32'(cap_addr));
            chk("rnd_hold_we_wdata", 32'({mem_we, mem_wdata}), 32'({cap_we, cap_wdata}));
         end
         if (outst && n == due + 1) begin
            chk("rnd_done", 32'({aud_done, cpu_done}), 32'(m_owner ? 2'b01 : 2'b10));
            chk("rnd_rdata", 32'(rdata), 32'(exp_rd));
            outst = 0;
         end else
            chk("rnd_no_done", 32'({aud_done, cpu_done}), 32'd0);

         if (mem_start) begin
            exp_w = prev_c && (!prev_a || m_starve == SMAX);
            chk("rnd_no_overlap", 32'(outst), 32'd0);
            chk("rnd_req_and_free", 32'({prev_a | prev_c, prev_busy}), 32'(2'b10));
            chk("rnd_gnt", 32'({aud_gnt, cpu_gnt}), 32'(exp_w ? 2'b01 : 2'b10));
            cap_addr  = exp_w ? cpu_addr : aud_addr;
            cap_wdata = exp_w ? cpu_wdata : aud_wdata;
            cap_we    = exp_w ? cpu_we : aud_we;
            chk("rnd_cap_addr", 32'(mem_addr), 32'(cap_addr));
            chk("rnd_cap_we_wdata", 32'({mem_we, mem_wdata}), 32'({cap_we, cap_wdata}));
            if (exp_w) m_starve = 0;
            else if (prev_c && m_starve < SMAX) m_starve++;
            m_owner = exp_w;
            outst = 1;
            due = n + int'($urandom_range(1, 8));
            grants++;
            if (exp_w) cpu_req = 0; else aud_req = 0;
         end else
            chk("rnd_no_gnt", 32'({aud_gnt, cpu_gnt}), 32'd0);
         chk("rnd_owner", 32'(owner), 32'(m_owner));

         mem_done = outst && (n == due);
         if (mem_done) begin
            exp_rd = 8'($urandom);
            mem_rdata = exp_rd;
         end else begin
            mem_rdata = 8'($urandom);
            if (!outst && $urandom_range(0, 9) == 0) mem_done = 1;
         end
         if (!aud_req && $urandom_range(0, 1) == 0) begin
            aud_req = 1; aud_we = 1'($urandom); aud_addr = 24'($urandom); aud_wdata = 8'($urandom);
         end
         if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 24'($urandom); cpu_wdata = 8'($urandom);
         end
         mem_busy = ($urandom_range(0, 4) == 0);
         prev_a = aud_req; prev_c = cpu_req; prev_busy = mem_busy;
         step();
      end
      chk("rnd_enough_grants", 32'(grants > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
